// File: rtl/step_to_position.sv
// Step/dir receiver: decodes an async STEP/DIR pulse train into position and step period.
// Optional dir-setup checking and dir_violation_o are compiled in with STEP_DIR_SETUP_CHECK_EN.
module step_to_position #(
  parameter int SIZE         = 32,
  parameter int PERIOD_WIDTH = 24,
  parameter int MIN_PERIOD   = 4,
  parameter int TIMEOUT      = 250000,
  parameter int DIR_SETUP    = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    enable_i,
  input  logic                    clear_i,
  input  logic                    step_i,
  input  logic                    dir_i,
  output logic [SIZE-1:0]         position_o,
  output logic                    step_strobe_o,
  output logic [PERIOD_WIDTH-1:0] period_o,
  output logic                    period_valid_o,
  output logic                    moving_o,
  output logic                    overspeed_o
`ifdef STEP_DIR_SETUP_CHECK_EN
  ,
  output logic                    dir_violation_o
`endif
);

  if (TIMEOUT < 2 || DIR_SETUP < 1 ||
      64'(TIMEOUT) >= (64'd1 << PERIOD_WIDTH)) begin : g_param_err
    $error("step_to_position: illegal TIMEOUT/DIR_SETUP/PERIOD_WIDTH");
  end

  localparam logic [PERIOD_WIDTH-1:0] TO_MAX = PERIOD_WIDTH'(TIMEOUT);
  localparam logic [PERIOD_WIDTH-1:0] TO_M1  = PERIOD_WIDTH'(TIMEOUT - 1);
  localparam logic [PERIOD_WIDTH-1:0] MIN_P  = PERIOD_WIDTH'(MIN_PERIOD);

  typedef enum logic [1:0] {IDLE, FIRST, TRACK} state_t;

  state_t state_q, state_d;

  logic step_m, step_s, step_d;
  logic dir_m, dir_s;
  logic evt;

  logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic [PERIOD_WIDTH-1:0] period_d;
  logic [SIZE-1:0]         pos_d;
  logic                    valid_d, strobe_d, ovs_d;

  assign evt      = step_s & ~step_d & enable_i;
  assign cnt_inc  = cnt_q + 1'b1;
  assign moving_o = (state_q != IDLE);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      step_m <= 1'b0;
      step_s <= 1'b0;
      step_d <= 1'b0;
      dir_m  <= 1'b0;
      dir_s  <= 1'b0;
    end else begin
      step_m <= step_i;
      step_s <= step_m;
      step_d <= step_s;
      dir_m  <= dir_i;
      dir_s  <= dir_m;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      position_o     <= '0;
      step_strobe_o  <= 1'b0;
      period_o       <= '0;
      period_valid_o <= 1'b0;
      overspeed_o    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      position_o     <= pos_d;
      step_strobe_o  <= strobe_d;
      period_o       <= period_d;
      period_valid_o <= valid_d;
      overspeed_o    <= ovs_d;
    end
  end

  // Clear is applied before the step so a coincident event lands on +/-1.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_o;
    valid_d  = period_valid_o;
    strobe_d = 1'b0;
    pos_d    = clear_i ? '0 : position_o;
    ovs_d    = clear_i ? 1'b0 : overspeed_o;
    if (!enable_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (evt) begin
            state_d = FIRST;
            cnt_d   = '0;
          end
        end
        FIRST, TRACK: begin
          cnt_d = (cnt_q == TO_MAX) ? cnt_q : cnt_inc;
          if (evt) begin
            state_d  = TRACK;
            cnt_d    = '0;
            period_d = cnt_inc;
            valid_d  = 1'b1;
            if (cnt_inc < MIN_P) ovs_d = 1'b1;
          end else if (cnt_q == TO_M1) begin
            state_d = IDLE;
            cnt_d   = '0;
            valid_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
      if (evt) begin
        strobe_d = 1'b1;
        pos_d    = dir_s ? pos_d + 1'b1 : pos_d - 1'b1;
      end
    end
  end

`ifdef STEP_DIR_SETUP_CHECK_EN
  localparam int DW = $clog2(DIR_SETUP + 1);
  localparam logic [DW-1:0] DS = DW'(DIR_SETUP);

  logic          dir_d;
  logic [DW-1:0] dir_cnt;
  logic [DW-1:0] dir_age;

  // A change visible this cycle means the direction is zero cycles old.
  assign dir_age = (dir_s != dir_d) ? '0 : dir_cnt;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      dir_d           <= 1'b0;
      dir_cnt         <= '0;
      dir_violation_o <= 1'b0;
    end else begin
      dir_d <= dir_s;
      if (dir_s != dir_d)  dir_cnt <= '0;
      else if (dir_cnt < DS) dir_cnt <= dir_cnt + 1'b1;
      if (evt && dir_age < DS) dir_violation_o <= 1'b1;
      else if (clear_i)        dir_violation_o <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_step_to_position.sv
// Directed bench for step_to_position with a strobe/position scoreboard.
// Expected positions and strobe cycles are queued at stimulus time.
module tb_step_to_position;

  localparam int SZ = 8;
  localparam int PW = 16;
  localparam int TO = 300;

  logic clk_i = 1'b0;
  logic reset_n_i = 1'b0;
  logic enable_i = 1'b0;
  logic clear_i = 1'b0;
  logic step_i = 1'b0;
  logic dir_i = 1'b0;
  logic [SZ-1:0] position_o;
  logic step_strobe_o;
  logic [PW-1:0] period_o;
  logic period_valid_o;
  logic moving_o;
  logic overspeed_o;
`ifdef STEP_DIR_SETUP_CHECK_EN
  logic dir_violation_o;
`endif

  step_to_position #(
    .SIZE(SZ), .PERIOD_WIDTH(PW), .MIN_PERIOD(4),
    .TIMEOUT(TO), .DIR_SETUP(8)
  ) dut (
    .clk_i(clk_i),
    .reset_n_i(reset_n_i),
    .enable_i(enable_i),
    .clear_i(clear_i),
    .step_i(step_i),
    .dir_i(dir_i),
    .position_o(position_o),
    .step_strobe_o(step_strobe_o),
    .period_o(period_o),
    .period_valid_o(period_valid_o),
    .moving_o(moving_o),
    .overspeed_o(overspeed_o)
`ifdef STEP_DIR_SETUP_CHECK_EN
    ,
    .dir_violation_o(dir_violation_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [SZ-1:0] pos;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int n_pass = 0;
  int n_total = 0;
  logic [SZ-1:0] exp_pos = '0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  always @(negedge clk_i) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      check("strobe_late", cyc, sb[0].cyc);
      void'(sb.pop_front());
    end
    if (step_strobe_o) begin
      if (sb.size() == 0) begin
        check("strobe_spurious", 32'(step_strobe_o), 0);
      end else begin
        e = sb.pop_front();
        check("strobe_cyc", cyc, e.cyc);
        check("strobe_pos", 32'(position_o), 32'(e.pos));
      end
    end
  end

  // Rising step edges are spaced 'gap' cycles apart.
  task automatic step(input logic d, input int gap, input bit counted);
    @(negedge clk_i);
    dir_i = d;
    step_i = 1'b1;
    if (counted) begin
      exp_pos = d ? exp_pos + 1'b1 : exp_pos - 1'b1;
      sb.push_back('{pos: exp_pos, cyc: cyc + 3});
    end
    @(negedge clk_i);
    step_i = 1'b0;
    repeat (gap - 2) @(negedge clk_i);
  endtask

  task automatic step_clear(input logic d, input int gap);
    @(negedge clk_i);
    dir_i = d;
    step_i = 1'b1;
    exp_pos = d ? SZ'(1) : '1;
    sb.push_back('{pos: exp_pos, cyc: cyc + 3});
    @(negedge clk_i);
    step_i = 1'b0;
    @(negedge clk_i);
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    repeat (gap - 4) @(negedge clk_i);
  endtask

  task automatic clear_pulse();
    @(negedge clk_i);
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    exp_pos = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pos"}, 32'(position_o), 0);
    check({tag, "_strobe"}, 32'(step_strobe_o), 0);
    check({tag, "_period"}, 32'(period_o), 0);
    check({tag, "_valid"}, 32'(period_valid_o), 0);
    check({tag, "_moving"}, 32'(moving_o), 0);
    check({tag, "_ovs"}, 32'(overspeed_o), 0);
  endtask

  initial begin
    #1000000;
    $error("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    enable_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check_all_zero("reset");
    reset_n_i = 1'b1;
    repeat (3) @(negedge clk_i);

    step(1'b1, 20, 1'b1);
    check("first_valid", 32'(period_valid_o), 0);
    check("first_moving", 32'(moving_o), 1);
    for (int i = 0; i < 4; i++) step(1'b1, 20, 1'b1);
    check("run_pos", 32'(position_o), 5);
    check("run_period", 32'(period_o), 20);
    check("run_valid", 32'(period_valid_o), 1);
    check("run_moving", 32'(moving_o), 1);

    clear_pulse();
    check("clear_pos", 32'(position_o), 0);
    for (int i = 0; i < 3; i++) step(1'b1, 20, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, 20, 1'b1);
    check("updown_pos", 32'(position_o), 32'hFC);
    repeat (TO + 20) @(negedge clk_i);
    check("to_moving", 32'(moving_o), 0);
    check("to_valid", 32'(period_valid_o), 0);
    check("to_period", 32'(period_o), 20);

    clear_pulse();
    step(1'b1, 2, 1'b1);
    step(1'b1, 20, 1'b1);
    check("ovs_pos", 32'(position_o), 2);
    check("ovs_flag", 32'(overspeed_o), 1);
    check("ovs_period", 32'(period_o), 2);
    step_clear(1'b1, 20);
    check("clrstep_pos", 32'(position_o), 1);
    check("clrstep_ovs", 32'(overspeed_o), 0);
    check("clrstep_period", 32'(period_o), 20);

    clear_pulse();
    for (int i = 0; i < 127; i++) step(1'b1, 5, 1'b1);
    check("wrap_max", 32'(position_o), 32'h7F);
    step(1'b1, 5, 1'b1);
    check("wrap_min", 32'(position_o), 32'h80);
    check("wrap_ovs", 32'(overspeed_o), 0);

    @(negedge clk_i);
    enable_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("dis_moving", 32'(moving_o), 0);
    check("dis_valid", 32'(period_valid_o), 0);
    for (int i = 0; i < 4; i++) step(1'b1, 10, 1'b0);
    check("dis_pos", 32'(position_o), 32'(exp_pos));
    check("dis_moving2", 32'(moving_o), 0);
    @(negedge clk_i);
    enable_i = 1'b1;
    repeat (3) @(negedge clk_i);
    step(1'b0, 20, 1'b1);
    check("reen_valid1", 32'(period_valid_o), 0);
    check("reen_moving", 32'(moving_o), 1);
    step(1'b0, 20, 1'b1);
    check("reen_valid2", 32'(period_valid_o), 1);
    check("reen_pos", 32'(position_o), 32'h7E);

    @(negedge clk_i);
    dir_i = 1'b1;
    step_i = 1'b1;
    @(negedge clk_i);
    reset_n_i = 1'b0;
    step_i = 1'b0;
    @(negedge clk_i);
    check_all_zero("midreset");
    reset_n_i = 1'b1;
    exp_pos = '0;
    repeat (10) @(negedge clk_i);
    check("postreset_pos", 32'(position_o), 0);

    @(negedge clk_i);
    step_i = 1'b1;
    exp_pos = exp_pos + 1'b1;
    sb.push_back('{pos: exp_pos, cyc: cyc + 3});
    repeat (30) @(negedge clk_i);
    check("held_pos", 32'(position_o), 1);
    step_i = 1'b0;
    repeat (5) @(negedge clk_i);

`ifdef STEP_DIR_SETUP_CHECK_EN
    clear_pulse();
    @(negedge clk_i);
    dir_i = 1'b0;
    repeat (2) @(negedge clk_i);
    step(1'b0, 20, 1'b1);
    check("dirv_set", 32'(dir_violation_o), 1);
    clear_pulse();
    check("dirv_clear", 32'(dir_violation_o), 0);
    repeat (20) @(negedge clk_i);
    step(1'b0, 20, 1'b1);
    check("dirv_stable", 32'(dir_violation_o), 0);
    check("dirv_pos", 32'(position_o), 32'(exp_pos));
`endif

    repeat (10) @(negedge clk_i);
    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
